rle_pixel_decoder: RTL and testbench

Run-length decoder that feeds the 640x480 VGA timing/output stage. Accepts 16-bit RLE tokens (run + 9-bit RRRGGGBBB colour) from the video source through a small token FIFO. Expands each token into per-pixel colour, one pixel per cycle in which the VGA stage asserts display-active. Drives the VGA stage's colour input and colour-valid input directly.

---
 rtl/vga_video_pkg.sv | 22 ++
 rtl/rle_token_fifo.sv | 44 ++++
 rtl/rle_pixel_decoder.sv | 86 ++++++++
 tb/tb_rle_pixel_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_video_pkg.sv
// Shared widths, token layout and decoder state encoding for the RLE pixel path
// into the 640x480 VGA output stage.
package vga_video_pkg;
    localparam int COLOR_W      = 9;
    localparam int RUN_W        = 7;
    localparam int TOKEN_W      = 16;
    localparam int CNT_W        = 19;

    localparam int H_DISPLAY    = 640;
    localparam int V_DISPLAY    = 480;
    localparam int FRAME_PIXELS = H_DISPLAY * V_DISPLAY;

    localparam int COLOR_LSB    = 0;
    localparam int COLOR_MSB    = COLOR_LSB + COLOR_W - 1;
    localparam int RUN_LSB      = COLOR_MSB + 1;
    localparam int RUN_MSB      = RUN_LSB + RUN_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/rle_token_fifo.sv
// Small synchronous token FIFO with an extra wrap bit on each pointer so that
// full and empty are distinguished without a separate occupancy counter.
module rle_token_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rle_pixel_decoder.sv
// Expands RLE tokens into one pixel per display-active cycle for the VGA stage.
//   state | meaning
//   IDLE  | no run loaded; colour outputs forced to zero
//   RUN   | color_out holds the current run colour; remaining = pixels left - 1
module rle_pixel_decoder
    import vga_video_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TOKEN_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               pixel_req,
    input  logic               frame_start,
    output logic [COLOR_W-1:0] color_out,
    output logic               color_valid,
    output logic               underflow,
    output logic [CNT_W-1:0]   pixel_count
);
    state_t             state;
    logic [RUN_W-1:0]   remaining;
    logic [TOKEN_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               emit;
    logic               starve;

    assign in_ready = !fifo_full;
    assign emit     = (state == RUN) && pixel_req;
    assign starve   = (state == IDLE) && pixel_req;
    // Reload on the last pixel of a run so consecutive runs have no bubble.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || (emit && (remaining == '0)));

    rle_token_fifo #(
        .WIDTH (TOKEN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            color_out   <= '0;
            color_valid <= 1'b0;
            underflow   <= 1'b0;
            pixel_count <= '0;
        end else begin
            if (fifo_pop) begin
                state       <= RUN;
                remaining   <= fifo_dout[RUN_MSB:RUN_LSB];
                color_out   <= fifo_dout[COLOR_MSB:COLOR_LSB];
                color_valid <= 1'b1;
            end else if (emit) begin
                if (remaining != '0) begin
                    remaining <= remaining - {{(RUN_W-1){1'b0}}, 1'b1};
                end else begin
                    state       <= IDLE;
                    color_out   <= '0;
                    color_valid <= 1'b0;
                end
            end

            // frame_start clears first; a same-cycle event still lands.
            if (frame_start) begin
                underflow   <= starve;
                pixel_count <= {{(CNT_W-1){1'b0}}, emit};
            end else begin
                underflow   <= underflow | starve;
                pixel_count <= pixel_count + {{(CNT_W-1){1'b0}}, emit};
            end
        end
    end
endmodule

// File: tb/tb_rle_pixel_decoder.sv
// Directed checks of the RLE pixel decoder: reset, runs, back-to-back tokens,
// FIFO backpressure, stalls and frame_start interaction.
module tb_rle_pixel_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        pixel_req;
    logic        frame_start;
    logic [8:0]  color_out;
    logic        color_valid;
    logic        underflow;
    logic [18:0] pixel_count;

    int checks   = 0;
    int failures = 0;
    int accepted;

    rle_pixel_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pixel_req   (pixel_req),
        .frame_start (frame_start),
        .color_out   (color_out),
        .color_valid (color_valid),
        .underflow   (underflow),
        .pixel_count (pixel_count)
    );

    always #20 clk = ~clk;

    function automatic logic [15:0] tok(input int run, input int color);
        logic [6:0] r;
        logic [8:0] c;
        r = run[6:0];
        c = color[8:0];
        return {r, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input logic [15:0] t);
        in_data  = t;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_data = '0; in_valid = 1'b0; pixel_req = 1'b0; frame_start = 1'b0;
        do_reset();
        check("reset_valid", 32'(color_valid), 32'h0);
        check("reset_ready", 32'(in_ready), 32'h1);
        check("reset_count", 32'(pixel_count), 32'h0);

        // 1: async reset mid-stream with tokens queued
        pixel_req = 1'b1; tick(); pixel_req = 1'b0;
        check("t1_underflow_pre", 32'(underflow), 32'h1);
        push(tok(1, 9'h155)); push(tok(1, 9'h0F0)); push(tok(1, 9'h00F));
        pixel_req = 1'b1; tick(); pixel_req = 1'b0;
        check("t1_count_pre", 32'(pixel_count), 32'h1);
        check("t1_valid_pre", 32'(color_valid), 32'h1);
        #5 rst = 1'b1;
        #1;
        check("t1_rst_valid", 32'(color_valid), 32'h0);
        check("t1_rst_color", 32'(color_out), 32'h0);
        check("t1_rst_ready", 32'(in_ready), 32'h1);
        check("t1_rst_underflow", 32'(underflow), 32'h0);
        check("t1_rst_count", 32'(pixel_count), 32'h0);
        tick(); rst = 1'b0; tick();
        pixel_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_no_stale", 32'(color_valid), 32'h0);
            tick();
        end
        pixel_req = 1'b0;
        check("t1_count_post", 32'(pixel_count), 32'h0);

        // 2: single run of 4 pixels then underflow
        do_reset();
        push(tok(3, 9'h1FF)); tick();
        pixel_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_color", 32'(color_out), 32'h1FF);
            check("t2_valid", 32'(color_valid), 32'h1);
            tick();
        end
        check("t2_valid_end", 32'(color_valid), 32'h0);
        check("t2_color_end", 32'(color_out), 32'h0);
        tick();
        pixel_req = 1'b0;
        check("t2_underflow", 32'(underflow), 32'h1);
        check("t2_count", 32'(pixel_count), 32'h4);

        // 3: back-to-back tokens, no bubble
        do_reset();
        push(tok(0, 9'h007)); push(tok(1, 9'h038)); push(tok(0, 9'h1C0));
        pixel_req = 1'b1;
        check("t3_p0", 32'(color_out), 32'h007); tick();
        check("t3_p1", 32'(color_out), 32'h038); tick();
        check("t3_p2", 32'(color_out), 32'h038); tick();
        check("t3_p3", 32'(color_out), 32'h1C0);
        check("t3_v3", 32'(color_valid), 32'h1); tick();
        pixel_req = 1'b0;
        check("t3_count", 32'(pixel_count), 32'h4);
        check("t3_no_underflow", 32'(underflow), 32'h0);

        // 4: backpressure, capacity FIFO_DEPTH+1
        do_reset();
        accepted = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = tok(2, 9'h100 + i);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("t4_accepted", 32'(accepted), 32'd5);
        check("t4_ready_full", 32'(in_ready), 32'h0);
        check("t4_first_color", 32'(color_out), 32'h100);
        pixel_req = 1'b1;
        tick(); tick();
        check("t4_ready_2px", 32'(in_ready), 32'h0);
        tick();
        pixel_req = 1'b0;
        check("t4_ready_3px", 32'(in_ready), 32'h1);
        check("t4_next_color", 32'(color_out), 32'h101);

        // 5: stall holds colour
        do_reset();
        push(tok(5, 9'h0AA)); tick();
        pixel_req = 1'b1; check("t5_c0", 32'(color_out), 32'h0AA); tick();
        pixel_req = 1'b0; check("t5_c1", 32'(color_out), 32'h0AA); tick();
        check("t5_c2", 32'(color_out), 32'h0AA); tick();
        pixel_req = 1'b1; check("t5_c3", 32'(color_out), 32'h0AA); tick();
        pixel_req = 1'b0;
        check("t5_count", 32'(pixel_count), 32'h2);
        check("t5_valid", 32'(color_valid), 32'h1);

        // 6: frame_start ordering against same-cycle events
        do_reset();
        pixel_req = 1'b1; frame_start = 1'b1; tick();
        pixel_req = 1'b0; frame_start = 1'b0;
        check("t6_underflow_set", 32'(underflow), 32'h1);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("t6_underflow_clr", 32'(underflow), 32'h0);
        push(tok(3, 9'h0C3)); tick();
        pixel_req = 1'b1; tick(); tick();
        check("t6_count_pre", 32'(pixel_count), 32'h2);
        frame_start = 1'b1; tick();
        frame_start = 1'b0; pixel_req = 1'b0;
        check("t6_count_fs", 32'(pixel_count), 32'h1);
        check("t6_no_underflow", 32'(underflow), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
